// File: rtl/dispatch_nw_pkg.sv
// rtl/dispatch_nw_pkg.sv - shared types and sizes for the N-wide dispatch stage
package dispatch_nw_pkg;

  localparam int DISPATCH_WIDTH  = 2;
  localparam int DISPATCH_DEPTH  = 8;
  localparam int DISPATCH_NUM_RS = 3;
  localparam int RS_SEL_W        = $clog2(DISPATCH_NUM_RS);

  typedef enum logic [RS_SEL_W-1:0] {
    RS_ALU,
    RS_MDU,
    RS_LSQ
  } rs_sel_t;

  typedef struct packed {
    rs_sel_t    rs_sel;
    logic [5:0] pdst;
    logic [7:0] uop;
  } renamed_inst_t;

  function automatic logic rs_sel_in_range(input rs_sel_t sel, input int num_rs);
    return int'(sel) < num_rs;
  endfunction

endpackage

// File: rtl/dispatch_nw_if.sv
// rtl/dispatch_nw_if.sv - rename/RS/ROB facing bus of the dispatch stage
interface dispatch_nw_if
  import dispatch_nw_pkg::*;
#(
  parameter int WIDTH  = DISPATCH_WIDTH,
  parameter int DEPTH  = DISPATCH_DEPTH,
  parameter int NUM_RS = DISPATCH_NUM_RS
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                             flush;
  logic                             cache_stall;
  logic [WIDTH-1:0]                 in_valid;
  renamed_inst_t [WIDTH-1:0]        in_inst;
  logic                             dispatch_rdy;
  logic [NUM_RS-1:0][CNT_W-1:0]     rs_free;
  logic [CNT_W-1:0]                 rob_free;
  renamed_inst_t [WIDTH-1:0]        out_inst;
  logic [NUM_RS-1:0][WIDTH-1:0]     rs_we;
  logic [WIDTH-1:0]                 rob_we;
  logic [OCC_W-1:0]                 occupancy;

  modport master (
    output flush, cache_stall, in_valid, in_inst, rs_free, rob_free,
    input  dispatch_rdy, out_inst, rs_we, rob_we, occupancy
  );

  modport slave (
    input  flush, cache_stall, in_valid, in_inst, rs_free, rob_free,
    output dispatch_rdy, out_inst, rs_we, rob_we, occupancy
  );

endinterface

// File: rtl/dispatch_nw_select.sv
// rtl/dispatch_nw_select.sv - combinational in-order prefix selector for dispatch slots
module dispatch_nw_select
  import dispatch_nw_pkg::*;
#(
  parameter int WIDTH  = DISPATCH_WIDTH,
  parameter int NUM_RS = DISPATCH_NUM_RS,
  parameter int CNT_W  = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]                i_cand_valid,
  input  logic                            i_block,
  input  logic [WIDTH-1:0][RS_SEL_W-1:0]  i_rs_sel,
  input  logic [NUM_RS-1:0][CNT_W-1:0]    i_rs_free,
  input  logic [CNT_W-1:0]                i_rob_free,
  output logic [WIDTH-1:0]                o_dispatched
);

  always_comb begin
    logic             w_chain;
    int               w_same;
    int               w_free;
    logic [WIDTH-1:0] w_disp;
    w_disp  = '0;
    w_chain = 1'b1;
    for (int k = 0; k < WIDTH; k++) begin
      w_same = 0;
      w_free = 0;
      // Older slots already headed to the same RS consume its free entries first.
      for (int j = 0; j < k; j++) begin
        if (w_disp[j] && (i_rs_sel[j] == i_rs_sel[k])) w_same = w_same + 1;
      end
      for (int r = 0; r < NUM_RS; r++) begin
        if (int'(i_rs_sel[k]) == r) w_free = int'(i_rs_free[r]);
      end
      w_chain = w_chain && i_cand_valid[k] && !i_block
                && rs_sel_in_range(rs_sel_t'(i_rs_sel[k]), NUM_RS)
                && (w_same < w_free) && (k < int'(i_rob_free));
      w_disp[k] = w_chain;
    end
    o_dispatched = w_disp;
  end

endmodule

// File: rtl/dispatch_nw.sv
// rtl/dispatch_nw.sv - N-wide in-order dispatch buffer between rename and RS/ROB
module dispatch_nw
  import dispatch_nw_pkg::*;
#(
  parameter int WIDTH  = DISPATCH_WIDTH,
  parameter int DEPTH  = DISPATCH_DEPTH,
  parameter int NUM_RS = DISPATCH_NUM_RS,
  parameter int CNT_W  = $clog2(WIDTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  dispatch_nw_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  renamed_inst_t                 r_mem [DEPTH];
  logic [PTR_W-1:0]              r_head;
  logic [PTR_W-1:0]              r_tail;
  logic [OCC_W-1:0]              r_count;

  logic                          w_rdy;
  logic                          w_block;
  logic [WIDTH-1:0]              w_cand;
  logic [WIDTH-1:0]              w_disp;
  logic [WIDTH-1:0][RS_SEL_W-1:0] w_rs_sel;
  renamed_inst_t [WIDTH-1:0]     w_out;
  logic [OCC_W-1:0]              w_enq_n;
  logic [OCC_W-1:0]              w_deq_n;

  // Ready looks only at the registered count so rename never sees RS/ROB timing.
  assign w_rdy   = (DEPTH - int'(r_count)) >= WIDTH;
  assign w_block = bus.cache_stall | bus.flush;

  always_comb begin
    w_cand   = '0;
    w_out    = '0;
    w_rs_sel = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (k < int'(r_count)) begin
        w_cand[k] = 1'b1;
        w_out[k]  = r_mem[r_head + PTR_W'(k)];
      end
      w_rs_sel[k] = w_out[k].rs_sel;
    end
  end

  dispatch_nw_select #(
    .WIDTH  (WIDTH),
    .NUM_RS (NUM_RS),
    .CNT_W  (CNT_W)
  ) u_select (
    .i_cand_valid (w_cand),
    .i_block      (w_block),
    .i_rs_sel     (w_rs_sel),
    .i_rs_free    (bus.rs_free),
    .i_rob_free   (bus.rob_free),
    .o_dispatched (w_disp)
  );

  always_comb begin
    w_enq_n = '0;
    w_deq_n = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (bus.in_valid[k]) w_enq_n = w_enq_n + OCC_W'(1);
      if (w_disp[k])       w_deq_n = w_deq_n + OCC_W'(1);
    end
    if (!w_rdy || bus.flush) w_enq_n = '0;
  end

  always_comb begin
    bus.rs_we = '0;
    for (int r = 0; r < NUM_RS; r++) begin
      for (int k = 0; k < WIDTH; k++) begin
        bus.rs_we[r][k] = w_disp[k] && (int'(w_out[k].rs_sel) == r);
      end
    end
  end

  assign bus.rob_we       = w_disp;
  assign bus.out_inst     = w_out;
  assign bus.dispatch_rdy = w_rdy;
  assign bus.occupancy    = r_count;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_deq_n);
      r_tail  <= r_tail + PTR_W'(w_enq_n);
      r_count <= r_count + w_enq_n - w_deq_n;
    end
  end

  // Valid slots are contiguous from 0, so slot k lands at tail+k.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && w_rdy) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (bus.in_valid[k]) r_mem[r_tail + PTR_W'(k)] <= bus.in_inst[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (w_cand[k]) assert (rs_sel_in_range(w_out[k].rs_sel, NUM_RS));
      end
    end
  end

endmodule

// File: tb/tb_dispatch_nw.sv
// tb/tb_dispatch_nw.sv - directed and randomized checks of dispatch_nw against a queue model
module tb_dispatch_nw;
  import dispatch_nw_pkg::*;

  localparam int W  = 2;
  localparam int D  = 8;
  localparam int R  = 3;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dispatch_nw_if #(.WIDTH(W), .DEPTH(D), .NUM_RS(R)) bus ();

  dispatch_nw #(.WIDTH(W), .DEPTH(D), .NUM_RS(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int            n_checks;
  int            n_errors;
  int            seq;
  int            exp_n;
  logic          exp_rdy;
  renamed_inst_t q[$];
  renamed_inst_t saved;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic renamed_inst_t mk(input int sel, input int id);
    renamed_inst_t t;
    t.rs_sel = rs_sel_t'(sel);
    t.pdst   = id[5:0];
    t.uop    = id[13:6];
    return t;
  endfunction

  task automatic drive(input logic [W-1:0] v, input int s0, input int s1);
    bus.in_valid   = v;
    bus.in_inst[0] = mk(s0, seq);
    seq = seq + 1;
    bus.in_inst[1] = mk(s1, seq);
    seq = seq + 1;
  endtask

  task automatic set_free(input int a, input int m, input int l, input int rob);
    bus.rs_free[0] = CW'(a);
    bus.rs_free[1] = CW'(m);
    bus.rs_free[2] = CW'(l);
    bus.rob_free   = CW'(rob);
  endtask

  task automatic settle();
    int                    used [R];
    int                    s;
    logic [W-1:0]          e_rob;
    logic [R-1:0][W-1:0]   e_rs;
    renamed_inst_t [W-1:0] e_out;
    @(negedge clk);
    exp_n   = 0;
    exp_rdy = 1'b0;
    if (rst) return;
    exp_rdy = (D - q.size()) >= W;
    foreach (used[i]) used[i] = 0;
    e_rob = '0;
    e_rs  = '0;
    e_out = '0;
    for (int k = 0; k < W; k++) begin
      if (k < q.size()) e_out[k] = q[k];
    end
    if (!bus.cache_stall && !bus.flush) begin
      for (int k = 0; k < W && k < q.size(); k++) begin
        s = int'(q[k].rs_sel);
        if (used[s] < int'(bus.rs_free[s]) && k < int'(bus.rob_free)) begin
          used[s]  = used[s] + 1;
          e_rob[k] = 1'b1;
          e_rs[s][k] = 1'b1;
          exp_n = exp_n + 1;
        end else begin
          break;
        end
      end
    end
    check("dispatch_rdy", 64'(bus.dispatch_rdy), 64'(exp_rdy));
    check("occupancy",    64'(bus.occupancy),    64'(q.size()));
    check("rob_we",       64'(bus.rob_we),       64'(e_rob));
    check("rs_we",        64'(bus.rs_we),        64'(e_rs));
    check("out_inst",     64'(bus.out_inst),     64'(e_out));
  endtask

  task automatic adv();
    if (rst || bus.flush) begin
      q.delete();
    end else begin
      repeat (exp_n) void'(q.pop_front());
      if (exp_rdy) begin
        for (int k = 0; k < W; k++) begin
          if (bus.in_valid[k]) q.push_back(bus.in_inst[k]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    settle();
    adv();
  endtask

  task automatic drain();
    drive(2'b00, 0, 0);
    for (int i = 0; i < 20 && q.size() > 0; i++) cycle();
    settle();
    check("drain_empty", 64'(bus.occupancy), 64'(0));
    adv();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    seq      = 1;
    bus.flush       = 1'b0;
    bus.cache_stall = 1'b0;
    bus.in_valid    = '0;
    bus.in_inst     = '0;
    set_free(2, 2, 2, 2);

    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    settle();
    check("rst_rdy",    64'(bus.dispatch_rdy), 64'(1));
    check("rst_occ",    64'(bus.occupancy),    64'(0));
    check("rst_rob_we", 64'(bus.rob_we),       64'(0));
    check("rst_rs_we",  64'(bus.rs_we),        64'(0));
    check("rst_out",    64'(bus.out_inst),     64'(0));
    adv();

    drive(2'b11, 0, 1);
    cycle();
    drive(2'b00, 0, 0);
    settle();
    check("tp1_rs_we_alu", 64'(bus.rs_we[0]),  64'(2'b01));
    check("tp1_rs_we_mdu", 64'(bus.rs_we[1]),  64'(2'b10));
    check("tp1_rob_we",    64'(bus.rob_we),    64'(2'b11));
    check("tp1_occ2",      64'(bus.occupancy), 64'(2));
    adv();
    settle();
    check("tp1_occ0", 64'(bus.occupancy), 64'(0));
    adv();

    set_free(1, 2, 2, 2);
    drive(2'b11, 0, 0);
    saved = bus.in_inst[1];
    cycle();
    drive(2'b00, 0, 0);
    settle();
    check("tp2_rob_we_a", 64'(bus.rob_we), 64'(2'b01));
    adv();
    settle();
    check("tp2_rob_we_b", 64'(bus.rob_we),      64'(2'b01));
    check("tp2_slot0",    64'(bus.out_inst[0]), 64'(saved));
    adv();

    set_free(2, 2, 0, 2);
    repeat (3) begin
      drive(2'b11, 2, 0);
      cycle();
    end
    drive(2'b01, 2, 0);
    cycle();
    drive(2'b00, 0, 0);
    settle();
    check("tp3_occ7",  64'(bus.occupancy),    64'(7));
    check("tp3_rdy0",  64'(bus.dispatch_rdy), 64'(0));
    check("tp3_no_we", 64'(bus.rob_we),       64'(0));
    adv();
    drive(2'b11, 0, 0);
    cycle();
    drive(2'b00, 0, 0);
    settle();
    check("tp3_hold7", 64'(bus.occupancy), 64'(7));
    adv();
    set_free(2, 2, 2, 2);
    drain();

    set_free(2, 2, 2, 1);
    drive(2'b11, 0, 1);
    cycle();
    drive(2'b00, 0, 0);
    settle();
    check("tp4_rob_we_a", 64'(bus.rob_we), 64'(2'b01));
    adv();
    settle();
    check("tp4_rob_we_b", 64'(bus.rob_we),    64'(2'b01));
    check("tp4_occ1",     64'(bus.occupancy), 64'(1));
    adv();
    set_free(2, 2, 2, 2);
    drain();

    set_free(0, 0, 0, 2);
    drive(2'b11, 0, 1);
    cycle();
    drive(2'b11, 2, 0);
    cycle();
    drive(2'b01, 1, 0);
    cycle();
    drive(2'b11, 0, 1);
    set_free(2, 2, 2, 2);
    bus.flush = 1'b1;
    settle();
    check("fl_occ5",  64'(bus.occupancy), 64'(5));
    check("fl_rob_we", 64'(bus.rob_we),   64'(0));
    check("fl_rs_we",  64'(bus.rs_we),    64'(0));
    adv();
    bus.flush = 1'b0;
    drive(2'b00, 0, 0);
    settle();
    check("fl_occ0", 64'(bus.occupancy),    64'(0));
    check("fl_rdy1", 64'(bus.dispatch_rdy), 64'(1));
    check("fl_out",  64'(bus.out_inst),     64'(0));
    adv();

    bus.cache_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      settle();
      check($sformatf("st_occ%0d", i), 64'(bus.occupancy), 64'(2 * i));
      check($sformatf("st_rob_we%0d", i), 64'(bus.rob_we), 64'(0));
      adv();
    end
    bus.cache_stall = 1'b0;
    drive(2'b00, 0, 0);
    settle();
    check("st_occ6", 64'(bus.occupancy), 64'(6));
    adv();
    drain();

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0:       drive(2'b00, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        1:       drive(2'b01, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        default: drive(2'b11, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      endcase
      set_free(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      bus.cache_stall = ($urandom_range(0, 7) == 0);
      bus.flush       = ($urandom_range(0, 31) == 0);
      rst             = ($urandom_range(0, 127) == 0);
      cycle();
    end
    rst             = 1'b0;
    bus.flush       = 1'b0;
    bus.cache_stall = 1'b0;
    set_free(2, 2, 2, 2);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dispatch_nw.md
Name: dispatch_nw

Overview:
- Parametrised N-wide dispatch stage between rename and the reservation stations (RS) / ROB.
- Replaces the fixed 2-wide, 3-target dispatch with a DEPTH-entry in-order dispatch buffer.
- Dispatches the longest in-order prefix of up to WIDTH head instructions whose target RS and the ROB both have room.
- Supports partial-group dispatch, a cache-stall freeze and a single-cycle flush.

Parameters:
- WIDTH, 2: instructions accepted from rename and dispatched per cycle.
- DEPTH, 8: dispatch buffer entries; power of two, DEPTH >= 2*WIDTH.
- NUM_RS, 3: number of RS targets (0=ALU, 1=MDU, 2=LSQ by default).
- CNT_W, $clog2(WIDTH+1): width of free-slot counts.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  pipeline flush.
- cache_stall  in  1  freezes dispatch; enqueue still allowed.
- in_valid  in  WIDTH  per-slot valid from rename; slot 0 is oldest; valid slots are contiguous from 0.
- in_inst  in  WIDTH x renamed_inst_t  renamed instructions.
- dispatch_rdy  out  1  buffer can accept a full WIDTH group next edge.
- rs_free  in  NUM_RS x CNT_W  free entries per RS, saturated at WIDTH.
- rob_free  in  CNT_W  free ROB entries, saturated at WIDTH.
- out_inst  out  WIDTH x renamed_inst_t  head group, slot 0 oldest, broadcast to all RS and the ROB.
- rs_we  out  NUM_RS x WIDTH  rs_we[r][k]=1 means RS r writes out_inst[k].
- rob_we  out  WIDTH  ROB allocate per slot.
- occupancy  out  $clog2(DEPTH+1)  valid entries held in the buffer.

Behaviour:
- Storage: circular queue with head/tail pointers of $clog2(DEPTH) bits plus a count register; pointers wrap modulo DEPTH.
- Enqueue:
  - When dispatch_rdy && |in_valid, write the valid slots at tail in order.
  - tail and count advance by popcount(in_valid).
  - dispatch_rdy = (DEPTH - count) >= WIDTH, computed from registered count only; there is no combinational path from rs_free or rob_free.
  - Any in_valid asserted while dispatch_rdy=0 is ignored; rename must hold.
- Dispatch candidate:
  - Candidate k (k < min(count, WIDTH)) is entry head+k.
  - out_inst[k] is driven from the buffer; unused slots are driven to '0.
- Dispatch selection, combinational, in order:
  - For k = 0..WIDTH-1, slot k dispatches iff:
    - slot k-1 dispatched (taken as true for k=0);
    - the candidate exists;
    - cache_stall=0 and flush=0;
    - (number of earlier dispatched slots with the same rs_sel) < rs_free[rs_sel];
    - k < rob_free.
  - The first slot that fails blocks all younger slots, giving a strict in-order prefix.
  - rs_we[r][k] = dispatched[k] && out_inst[k].rs_sel == r.
  - rob_we[k] = dispatched[k].
- Dequeue: head advances and count decrements by popcount(rob_we) at the edge.
- Simultaneous enqueue and dequeue in one cycle: count_next = count + enq - deq.
  - A full buffer with dispatch_rdy=0 still dispatches.
  - Entries enqueued at edge t are dispatchable from cycle t+1; there is no bypass, so latency is 1 cycle minimum.
- Empty buffer: all we outputs are 0; out_inst is '0.
- Flush (priority over enqueue and dispatch):
  - All we outputs are forced to 0 in the flush cycle.
  - At the edge: head=tail=0, count=0; inputs presented that cycle are dropped.
  - dispatch_rdy=1 from the next cycle.
- cache_stall: zero dispatch, buffer content held, enqueue continues.
- rs_sel out of range (>= NUM_RS): that slot blocks dispatch; an assertion fires in simulation.
- Reset (applies mid-operation identically):
  - head=tail=count=0.
  - Outputs after reset: dispatch_rdy=1, rs_we=0, rob_we=0, out_inst='0, occupancy=0.

Decomposition:
- uarch_pkg additions:
  - rs_sel_t: $clog2(NUM_RS)-bit enum RS_ALU/RS_MDU/RS_LSQ.
  - rs_sel field added to renamed_inst_t, set by decode.
  - Localparams DISPATCH_WIDTH and DISPATCH_DEPTH.
- Sub-module dispatch_select: purely combinational in-order prefix selector. Inputs: candidate valid, rs_sel, rs_free, rob_free. Output: dispatched[WIDTH]. Unit-tested separately.
- The queue stays in dispatch_nw.

Test Plan:
- Reset, then a 2-wide group (ALU, MDU) with rs_free={2,2,2} and rob_free=2 -> cycle t+1: rs_we[0]=01, rs_we[1]=10, rob_we=11; occupancy 2 then 0.
- Group (ALU, ALU) with rs_free[ALU]=1 -> only slot 0 dispatches; next cycle with rs_free[ALU]=1 the second ALU dispatches as out_inst[0].
- Group (LSQ, ALU) with rs_free[LSQ]=0 -> no dispatch, because the ALU op is blocked in order; the buffer fills, and dispatch_rdy drops to 0 at count=7 with DEPTH=8, WIDTH=2.
- rob_free=1 with 2 candidates -> rob_we=01 only; head advances by 1; pointer wrap checked across 20 mixed groups against a scoreboard.
- flush asserted while count=5 and in_valid=11 -> no we in that cycle; occupancy=0 and dispatch_rdy=1 next cycle; the flushed group is never dispatched.
- cache_stall held 3 cycles with continuous enqueue -> zero dispatch, occupancy rises 2/4/6; after release, order is preserved.
